// File: rtl/mt6835_angle_tracker.sv
// mt6835_angle_tracker: glitch-filtered multi-turn tracking, windowed velocity and electrical angle for the MT6835.
// Define MT6835_TRACK_DIR_INV_EN to reverse the positive direction for mirrored mounting.
module mt6835_angle_tracker #(
   parameter int ANGLE_W    = 21,
   parameter int POLE_PAIRS = 7,
   parameter int ELEC_W     = 12,
   parameter int TURN_W     = 16,
   parameter int MAX_STEP   = 262144,
   parameter int VEL_LOG2   = 4,
   parameter int FAULT_CNT  = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [ANGLE_W-1:0]          i_angle,
   input  logic                        i_angle_valid,
   input  logic [ANGLE_W-1:0]          i_offset,
   input  logic                        i_clear,
   output logic [ELEC_W-1:0]           o_elec_angle,
   output logic                        o_elec_valid,
   output logic [TURN_W-1:0]           o_turns,
   output logic [TURN_W+ANGLE_W-1:0]   o_position,
   output logic [ANGLE_W+VEL_LOG2-1:0] o_velocity,
   output logic                        o_vel_valid,
   output logic                        o_locked,
   output logic                        o_fault
);
   localparam int REJ_W = $clog2(FAULT_CNT + 1);
   localparam int VEL_W = ANGLE_W + VEL_LOG2;
   localparam logic signed [ANGLE_W-1:0] MAX_S = ANGLE_W'(MAX_STEP);
   localparam logic [ANGLE_W-1:0] PP = ANGLE_W'(POLE_PAIRS);

   typedef enum logic {ACQ, TRACK} state_t;
   state_t state, state_nxt;

   logic [ANGLE_W-1:0] angle, prev, corr, prod;
   logic signed [ANGLE_W-1:0] delta;
   logic [VEL_W-1:0] acc, dext;
   logic [VEL_LOG2-1:0] cnt;
   logic [REJ_W-1:0] rej;
   logic [TURN_W-1:0] turns;
   logic acquire, track_v, reject, accept, launch, fault_hit, win_done, s1_v, fwd_wrap, bwd_wrap;

`ifdef MT6835_TRACK_DIR_INV_EN
   assign angle = -i_angle;
`else
   assign angle = i_angle;
`endif

   assign acquire   = i_angle_valid && !i_clear && state == ACQ;
   assign track_v   = i_angle_valid && !i_clear && state == TRACK;
   assign delta     = angle - prev;
   assign dext      = {{VEL_LOG2{delta[ANGLE_W-1]}}, delta};
   // the most negative delta is caught by the lower bound, so no special case is needed
   assign reject    = track_v && (delta > MAX_S || delta < -MAX_S);
   assign accept    = track_v && !reject;
   assign launch    = acquire || accept;
   assign fault_hit = reject && rej == REJ_W'(FAULT_CNT - 1);
   assign win_done  = accept && cnt == '1;
   assign fwd_wrap  = !delta[ANGLE_W-1] && delta != '0 && angle < prev;
   assign bwd_wrap  = delta[ANGLE_W-1] && angle > prev;
   assign prod      = corr * PP;
   assign o_turns    = turns;
   assign o_position = {turns, prev};

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= ACQ;
      else state <= state_nxt;

   always_comb
      state_nxt = i_clear ? ACQ : acquire ? TRACK : fault_hit ? ACQ : state;

   always_comb
      o_locked = state == TRACK;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         prev         <= '0;
         turns        <= '0;
         acc          <= '0;
         cnt          <= '0;
         rej          <= '0;
         corr         <= '0;
         s1_v         <= 1'b0;
         o_elec_angle <= '0;
         o_elec_valid <= 1'b0;
         o_velocity   <= '0;
         o_vel_valid  <= 1'b0;
         o_fault      <= 1'b0;
      end else begin
         s1_v         <= launch;
         o_elec_valid <= s1_v;
         o_vel_valid  <= win_done;
         if (launch) corr <= angle - i_offset;
         if (s1_v) o_elec_angle <= prod[ANGLE_W-1 -: ELEC_W];
         if (i_clear) begin
            turns      <= '0;
            acc        <= '0;
            cnt        <= '0;
            rej        <= '0;
            o_fault    <= 1'b0;
            o_velocity <= '0;
         end else if (acquire) begin
            prev <= angle;
         end else if (reject) begin
            rej <= fault_hit ? '0 : rej + REJ_W'(1);
            if (fault_hit) o_fault <= 1'b1;
         end else if (accept) begin
            rej  <= '0;
            prev <= angle;
            cnt  <= cnt + VEL_LOG2'(1);
            acc  <= win_done ? '0 : acc + dext;
            if (win_done) o_velocity <= acc + dext;
            if (fwd_wrap) turns <= turns + TURN_W'(1);
            else if (bwd_wrap) turns <= turns - TURN_W'(1);
         end
      end
endmodule

// File: tb/tb_mt6835_angle_tracker.sv
// tb_mt6835_angle_tracker: directed scenarios plus randomized back-to-back traffic against
// an absolute-position reference model of the angle tracker.
module tb_mt6835_angle_tracker;
   localparam int AW = 21, TW = 16, EW = 12, VW = 25, PW = TW + AW;
   localparam longint MOD = 64'd1 << AW;
   localparam longint MSTEP = 262144;

   logic clk = 1'b0, rst_n = 1'b1, angle_valid = 1'b0, clear = 1'b0;
   logic [AW-1:0] angle = '0, offset = '0;
   logic [EW-1:0] o_elec_angle;
   logic o_elec_valid, o_vel_valid, o_locked, o_fault;
   logic [TW-1:0] o_turns;
   logic [PW-1:0] o_position;
   logic [VW-1:0] o_velocity;

   int n_cmp = 0, n_err = 0;

   bit m_locked, m_fault, m_vel_valid, m_ev, p1_v, m_took;
   int m_rej;
   longint m_pos, m_prev;
   longint m_q[$];
   logic [VW-1:0] m_vel;
   logic [EW-1:0] m_ea, p1_a;

   mt6835_angle_tracker dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_angle(angle), .i_angle_valid(angle_valid),
      .i_offset(offset), .i_clear(clear), .o_elec_angle(o_elec_angle),
      .o_elec_valid(o_elec_valid), .o_turns(o_turns), .o_position(o_position),
      .o_velocity(o_velocity), .o_vel_valid(o_vel_valid), .o_locked(o_locked), .o_fault(o_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [EW-1:0] elec_of(input longint a);
      longint c;
      c = (a - longint'(offset)) & (MOD - 1);
      return EW'(((c * 7) & (MOD - 1)) >> (AW - EW));
   endfunction

   task automatic model_reset;
      m_locked = 0; m_fault = 0; m_vel_valid = 0; m_ev = 0; p1_v = 0; m_took = 0;
      m_rej = 0; m_pos = 0; m_prev = 0; m_q.delete(); m_vel = '0; m_ea = '0; p1_a = '0;
   endtask

   // Position is kept as one absolute count; turns and {turns,angle} are views of it.
   task automatic model_edge(input bit v, input logic [AW-1:0] a, input bit clr);
      longint ae, d;
      ae = longint'(a);
`ifdef MT6835_TRACK_DIR_INV_EN
      ae = (MOD - ae) & (MOD - 1);
`endif
      m_ev = p1_v; m_ea = p1_a; p1_v = 0; m_vel_valid = 0; m_took = 0;
      if (clr) begin
         m_pos = m_prev; m_q.delete(); m_rej = 0; m_fault = 0; m_vel = '0; m_locked = 0;
      end else if (v && !m_locked) begin
         m_pos = ((m_pos >>> AW) <<< AW) + ae; m_prev = ae; m_locked = 1; p1_v = 1; m_took = 1;
      end else if (v) begin
         d = (ae - m_prev) & (MOD - 1);
         if (d >= MOD / 2) d -= MOD;
         if (d > MSTEP || d < -MSTEP) begin
            m_rej++;
            if (m_rej == 4) begin m_fault = 1; m_rej = 0; m_locked = 0; end
         end else begin
            m_rej = 0; m_pos += d; m_prev = ae; m_q.push_back(d); p1_v = 1; m_took = 1;
            if (m_q.size() == 16) begin m_vel = VW'(m_q.sum()); m_vel_valid = 1; m_q.delete(); end
         end
      end
      if (p1_v) p1_a = elec_of(ae);
   endtask

   task automatic cycle(input bit v, input logic [AW-1:0] a, input bit clr);
      angle_valid = v; angle = a; clear = clr;
      @(posedge clk); #1;
      model_edge(v, a, clr);
      angle_valid = 0; clear = 0;
   endtask

   task automatic test_reset;
      #2 rst_n = 0;
      @(posedge clk); #1;
      n_cmp++; if ({o_elec_valid, o_vel_valid, o_locked, o_fault} !== 4'b0) begin
         n_err++; $display("FAIL reset_flags got %b want 0000", {o_elec_valid, o_vel_valid, o_locked, o_fault}); end
      n_cmp++; if (o_turns !== '0 || o_position !== '0) begin
         n_err++; $display("FAIL reset_pos got turns %h pos %h want 0", o_turns, o_position); end
      n_cmp++; if (o_velocity !== '0 || o_elec_angle !== '0) begin
         n_err++; $display("FAIL reset_vel got vel %h elec %h want 0", o_velocity, o_elec_angle); end
      rst_n = 1; model_reset();
   endtask

   task automatic test_reset_midpipe;
      cycle(1, 21'h12345, 0);
      rst_n = 0; #1;
      n_cmp++; if (o_elec_valid !== 1'b0 || o_locked !== 1'b0) begin
         n_err++; $display("FAIL midreset_async got ev %b lk %b want 0 0", o_elec_valid, o_locked); end
      @(posedge clk); #1; rst_n = 1; model_reset();
      cycle(0, '0, 0);
      n_cmp++; if (o_elec_valid !== 1'b0) begin
         n_err++; $display("FAIL midreset_drop got ev %b want 0", o_elec_valid); end
   endtask

   task automatic test_acquire;
      offset = '0;
      cycle(1, 21'h000100, 0);
      n_cmp++; if (o_locked !== 1'b1 || o_turns !== 16'h0 || o_vel_valid !== 1'b0 || o_elec_valid !== 1'b0) begin
         n_err++; $display("FAIL acq_state got lk %b turns %h vv %b ev %b want 1 0 0 0", o_locked, o_turns, o_vel_valid, o_elec_valid); end
      cycle(0, '0, 0);
      n_cmp++; if (o_elec_valid !== 1'b1 || o_elec_angle !== 12'h003 || m_ea !== 12'h003) begin
         n_err++; $display("FAIL acq_elec got ev %b angle %h want 1 003", o_elec_valid, o_elec_angle); end
   endtask

   task automatic test_wrap;
      cycle(0, '0, 1);
      cycle(1, 21'h1FFF00, 0);
      cycle(1, 21'h000100, 0);
      n_cmp++; if (o_turns !== 16'h0001 || o_turns !== TW'(m_pos >>> AW)) begin
         n_err++; $display("FAIL wrap_fwd_turns got %h want 0001", o_turns); end
      n_cmp++; if (o_position !== {16'h0001, 21'h000100} || o_position !== PW'(m_pos)) begin
         n_err++; $display("FAIL wrap_fwd_pos got %h want %h", o_position, {16'h0001, 21'h000100}); end
      cycle(0, '0, 1);
      cycle(1, 21'h000100, 0);
      cycle(1, 21'h1FFF00, 0);
      n_cmp++; if (o_turns !== 16'hFFFF || o_turns !== TW'(m_pos >>> AW)) begin
         n_err++; $display("FAIL wrap_bwd_turns got %h want ffff", o_turns); end
   endtask

   task automatic test_fault;
      cycle(0, '0, 1);
      cycle(1, 21'h1FFF00, 0);
      cycle(1, 21'h000100, 0);
      for (int i = 0; i < 4; i++) begin
         cycle(1, 21'h100100, 0);
         if (i > 0) begin
            n_cmp++; if (o_elec_valid !== 1'b0) begin
               n_err++; $display("FAIL fault_no_elec[%0d] got ev %b want 0", i, o_elec_valid); end
         end
      end
      n_cmp++; if (o_fault !== 1'b1 || o_locked !== 1'b0 || m_fault !== 1'b1) begin
         n_err++; $display("FAIL fault_raise got fault %b lk %b want 1 0", o_fault, o_locked); end
      cycle(1, 21'h100100, 0);
      n_cmp++; if (o_elec_valid !== 1'b0) begin
         n_err++; $display("FAIL fault_last_elec got ev %b want 0", o_elec_valid); end
      n_cmp++; if (o_locked !== 1'b1 || o_turns !== 16'h0001 || o_fault !== 1'b1) begin
         n_err++; $display("FAIL fault_reacq got lk %b turns %h fault %b want 1 0001 1", o_locked, o_turns, o_fault); end
   endtask

   task automatic test_velocity;
      int seen;
      logic [VW-1:0] vel;
      seen = 0; vel = '0;
      cycle(0, '0, 1);
      for (int i = 0; i < 19; i++) begin
         if (i < 17) cycle(1, AW'(i * 'h100), 0);
         else cycle(0, '0, 0);
         if (o_vel_valid === 1'b1) begin seen++; vel = o_velocity; end
      end
      n_cmp++; if (seen !== 1) begin
         n_err++; $display("FAIL vel_pulses got %0d want 1", seen); end
      n_cmp++; if (vel !== 25'h1000) begin
         n_err++; $display("FAIL vel_value got %h want 0001000", vel); end
   endtask

   task automatic test_clear;
      cycle(0, '0, 1);
      cycle(1, '0, 0);
      for (int i = 1; i <= 24; i++) cycle(1, AW'(i * 'h40000), 0);
      n_cmp++; if (o_turns !== 16'h0003 || o_fault !== 1'b0) begin
         n_err++; $display("FAIL maxstep_turns got %h fault %b want 0003 0", o_turns, o_fault); end
      cycle(1, 21'h040001, 0);
      cycle(0, '0, 0);
      n_cmp++; if (o_elec_valid !== 1'b0 || o_turns !== 16'h0003 || o_position !== {16'h0003, 21'h0}) begin
         n_err++; $display("FAIL overstep_reject got ev %b pos %h want 0 %h", o_elec_valid, o_position, {16'h0003, 21'h0}); end
      cycle(1, 21'h000123, 1);
      n_cmp++; if (o_turns !== '0 || o_fault !== 1'b0 || o_locked !== 1'b0 || o_velocity !== '0) begin
         n_err++; $display("FAIL clear_state got turns %h fault %b lk %b vel %h want 0", o_turns, o_fault, o_locked, o_velocity); end
      cycle(0, '0, 0);
      n_cmp++; if (o_elec_valid !== 1'b0) begin
         n_err++; $display("FAIL clear_drop got ev %b want 0", o_elec_valid); end
      cycle(1, 21'h000555, 0);
      n_cmp++; if (o_locked !== 1'b1 || o_turns !== '0 || o_position !== PW'(m_pos)) begin
         n_err++; $display("FAIL clear_reacq got lk %b pos %h want 1 %h", o_locked, o_position, PW'(m_pos)); end
   endtask

   task automatic test_back_to_back;
      logic [AW-1:0] base, a;
      longint d;
      int r, bad;
      bit v, clr;
      bad = 0; base = '0;
      offset = AW'($urandom);
      cycle(0, '0, 1);
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 10) d = MSTEP + 1 + longint'($urandom_range(0, 32'(MOD - 2 * MSTEP - 2)));
         else if (r < 16) d = (r < 13) ? MSTEP : -MSTEP;
         else d = longint'($urandom_range(0, 2 * 262144)) - MSTEP;
         a = AW'(longint'(base) + d);
         v = $urandom_range(0, 3) != 0;
         clr = $urandom_range(0, 99) < 2;
         cycle(v, a, clr);
         if (m_took) base = a;
         n_cmp++; if ({o_locked, o_fault, o_elec_valid, o_vel_valid} !== {m_locked, m_fault, m_ev, m_vel_valid}) begin
            n_err++; bad++;
            if (bad < 10) $display("FAIL rnd_flags[%0d] got %b want %b", i, {o_locked, o_fault, o_elec_valid, o_vel_valid}, {m_locked, m_fault, m_ev, m_vel_valid}); end
         n_cmp++; if (o_position !== PW'(m_pos) || o_turns !== TW'(m_pos >>> AW)) begin
            n_err++; bad++;
            if (bad < 10) $display("FAIL rnd_pos[%0d] got %h want %h", i, o_position, PW'(m_pos)); end
         n_cmp++; if (o_velocity !== m_vel) begin
            n_err++; bad++;
            if (bad < 10) $display("FAIL rnd_vel[%0d] got %h want %h", i, o_velocity, m_vel); end
         if (m_ev) begin
            n_cmp++; if (o_elec_angle !== m_ea) begin
               n_err++; bad++;
               if (bad < 10) $display("FAIL rnd_elec[%0d] got %h want %h", i, o_elec_angle, m_ea); end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_reset_midpipe();
      test_acquire();
      test_wrap();
      test_fault();
      test_velocity();
      test_clear();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
